// File: rtl/branch_squash_ctrl_pkg.sv
// rtl/branch_squash_ctrl_pkg.sv - shared types, FSM states and ROB age compare for branch squash control
package branch_squash_ctrl_pkg;

    localparam int XLEN                = 32;
    localparam int ROB_IDX_W           = 6;
    localparam int RESTORE_TIMEOUT_DEF = 15;

    typedef logic [XLEN-1:0] xdef_t;

    typedef struct packed {
        logic                 flag;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef struct packed {
        robIdx_t rob_idx;
        logic    has_mispred;
        logic    branch_taken;
        xdef_t   target_pc;
        xdef_t   branch_npc;
    } branchwbInfo_t;

    typedef struct packed {
        logic  dueToBranch;
        logic  branch_taken;
        xdef_t arch_pc;
    } squashInfo_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PENDING,
        ST_SQUASH,
        ST_RECOVER
    } bsq_state_e;

    // The wrap flag flips each lap of the ROB, so a differing flag inverts the index ordering.
    function automatic logic rob_older(input robIdx_t a, input robIdx_t b);
        return ((a.flag == b.flag) && (a.idx < b.idx)) ||
               ((a.flag != b.flag) && (a.idx > b.idx));
    endfunction

endpackage

// File: rtl/branch_oldest_sel.sv
// rtl/branch_oldest_sel.sv - combinational oldest-mispredict selector across branch writeback ports
module branch_oldest_sel
    import branch_squash_ctrl_pkg::*;
#(
    parameter int NUM_BRU = 2,
    parameter int IDX_W   = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1
) (
    input  logic [NUM_BRU-1:0] wb_vld,
    input  branchwbInfo_t      wb_info [NUM_BRU],
    output logic               sel_vld,
    output logic [IDX_W-1:0]   sel_port,
    output branchwbInfo_t      sel_info
);

    // Scan ports low to high; only a strictly older entry displaces the current pick, so ties keep the lowest port.
    always_comb begin
        sel_vld  = 1'b0;
        sel_port = '0;
        sel_info = '0;
        for (int i = 0; i < NUM_BRU; i++) begin
            if (wb_vld[i] && wb_info[i].has_mispred &&
                (!sel_vld || rob_older(wb_info[i].rob_idx, sel_info.rob_idx))) begin
                sel_vld  = 1'b1;
                sel_port = IDX_W'(i);
                sel_info = wb_info[i];
            end
        end
    end

endmodule

// File: rtl/branch_squash_ctrl.sv
// rtl/branch_squash_ctrl.sv - mispredict recovery sequencer; optional BRANCH_SQUASH_EARLY_REDIRECT_EN adds early redirect
module branch_squash_ctrl
    import branch_squash_ctrl_pkg::*;
#(
    parameter int NUM_BRU         = 2,
    parameter int RESTORE_TIMEOUT = RESTORE_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BRU-1:0] i_wb_vld,
    input  branchwbInfo_t      i_wb_info [NUM_BRU],
    input  robIdx_t            i_rob_head_idx,
    input  logic               i_commit_vld,
    input  logic               i_ext_flush,
    input  logic               i_restore_done,
    output logic               o_squash_vld,
    output squashInfo_t        o_squash_info,
    output logic               o_commit_block,
    output logic               o_pend_vld,
    output robIdx_t            o_pend_rob_idx,
`ifdef BRANCH_SQUASH_EARLY_REDIRECT_EN
    output logic               o_early_redirect_vld,
    output xdef_t              o_early_redirect_pc,
`endif
    output logic               o_restore_timeout
);

    localparam int SEL_W = (NUM_BRU > 1) ? $clog2(NUM_BRU) : 1;
    localparam int CNT_W = $clog2(RESTORE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESTORE_TIMEOUT);

    bsq_state_e       state;
    logic             held_taken;
    xdef_t            held_pc;
    logic [CNT_W-1:0] restore_cnt;

    logic             sel_vld;
    logic [SEL_W-1:0] sel_port;
    branchwbInfo_t    sel_info;
    logic             cand_vld;
    xdef_t            cand_pc;
    logic             commit_match;
    logic             capture_en;
    logic [CNT_W-1:0] cnt_inc;

    branch_oldest_sel #(
        .NUM_BRU (NUM_BRU),
        .IDX_W   (SEL_W)
    ) u_sel (
        .wb_vld   (i_wb_vld),
        .wb_info  (i_wb_info),
        .sel_vld  (sel_vld),
        .sel_port (sel_port),
        .sel_info (sel_info)
    );

    // Capture decision: a match on the held branch always beats a new candidate, and a flush beats both.
    always_comb begin
        cand_vld     = sel_vld && sel_info.has_mispred && i_wb_vld[sel_port];
        cand_pc      = sel_info.branch_taken ? sel_info.target_pc : sel_info.branch_npc;
        commit_match = (state == ST_PENDING) && i_commit_vld && (i_rob_head_idx == o_pend_rob_idx);
        capture_en   = cand_vld && !i_ext_flush &&
                       ((state == ST_IDLE) ||
                        ((state == ST_PENDING) && !commit_match &&
                         rob_older(sel_info.rob_idx, o_pend_rob_idx)));
        cnt_inc      = (restore_cnt == CNT_MAX) ? restore_cnt : restore_cnt + 1'b1;
    end

    // Recovery FSM with all outputs registered alongside the state transitions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_IDLE;
            held_taken        <= 1'b0;
            held_pc           <= '0;
            restore_cnt       <= '0;
            o_squash_vld      <= 1'b0;
            o_squash_info     <= '0;
            o_commit_block    <= 1'b0;
            o_pend_vld        <= 1'b0;
            o_pend_rob_idx    <= '0;
            o_restore_timeout <= 1'b0;
`ifdef BRANCH_SQUASH_EARLY_REDIRECT_EN
            o_early_redirect_vld <= 1'b0;
            o_early_redirect_pc  <= '0;
`endif
        end else begin
            o_squash_vld  <= 1'b0;
            o_squash_info <= '0;
`ifdef BRANCH_SQUASH_EARLY_REDIRECT_EN
            o_early_redirect_vld <= capture_en;
            o_early_redirect_pc  <= capture_en ? cand_pc : '0;
`endif
            if (i_ext_flush) begin
                state          <= ST_IDLE;
                o_pend_vld     <= 1'b0;
                o_commit_block <= 1'b0;
                o_pend_rob_idx <= '0;
                held_taken     <= 1'b0;
                held_pc        <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (capture_en) begin
                            state          <= ST_PENDING;
                            o_pend_vld     <= 1'b1;
                            o_pend_rob_idx <= sel_info.rob_idx;
                            held_taken     <= sel_info.branch_taken;
                            held_pc        <= cand_pc;
                        end
                    end
                    ST_PENDING: begin
                        if (commit_match) begin
                            state                     <= ST_SQUASH;
                            o_pend_vld                <= 1'b0;
                            o_squash_vld              <= 1'b1;
                            o_squash_info.dueToBranch <= 1'b1;
                            o_squash_info.branch_taken <= held_taken;
                            o_squash_info.arch_pc     <= held_pc;
                            o_commit_block            <= 1'b1;
                            restore_cnt               <= '0;
                        end else if (capture_en) begin
                            o_pend_rob_idx <= sel_info.rob_idx;
                            held_taken     <= sel_info.branch_taken;
                            held_pc        <= cand_pc;
                        end
                    end
                    ST_SQUASH: begin
                        state <= ST_RECOVER;
                    end
                    ST_RECOVER: begin
                        restore_cnt <= cnt_inc;
                        if (cnt_inc == CNT_MAX) begin
                            o_restore_timeout <= 1'b1;
                        end
                        if (i_restore_done) begin
                            state          <= ST_IDLE;
                            o_commit_block <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_branch_squash_ctrl.sv
// tb/tb_branch_squash_ctrl.sv - table-driven scoreboard bench for branch_squash_ctrl
module tb_branch_squash_ctrl;
    import branch_squash_ctrl_pkg::*;

    localparam int TMO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    wb_vld = '0;
    branchwbInfo_t wb_info [2];
    robIdx_t       head = '0;
    logic          commit_vld = 1'b0;
    logic          ext_flush = 1'b0;
    logic          restore_done = 1'b0;
    logic          squash_vld;
    squashInfo_t   squash_info;
    logic          commit_block;
    logic          pend_vld;
    robIdx_t       pend_rob_idx;
    logic          restore_timeout;
`ifdef BRANCH_SQUASH_EARLY_REDIRECT_EN
    logic          early_vld;
    xdef_t         early_pc;
`endif

    int checks = 0;
    int failures = 0;

    branch_squash_ctrl #(.NUM_BRU(2), .RESTORE_TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_wb_vld          (wb_vld),
        .i_wb_info         (wb_info),
        .i_rob_head_idx    (head),
        .i_commit_vld      (commit_vld),
        .i_ext_flush       (ext_flush),
        .i_restore_done    (restore_done),
        .o_squash_vld      (squash_vld),
        .o_squash_info     (squash_info),
        .o_commit_block    (commit_block),
        .o_pend_vld        (pend_vld),
        .o_pend_rob_idx    (pend_rob_idx),
`ifdef BRANCH_SQUASH_EARLY_REDIRECT_EN
        .o_early_redirect_vld (early_vld),
        .o_early_redirect_pc  (early_pc),
`endif
        .o_restore_timeout (restore_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    vld;
        branchwbInfo_t w0;
        branchwbInfo_t w1;
        logic          cvld;
        robIdx_t       head;
        logic          flush;
        logic          rdone;
        logic          e_sq;
        squashInfo_t   e_info;
        logic          e_cb;
        logic          e_pv;
        robIdx_t       e_pidx;
        logic          e_tmo;
    } row_t;

    row_t rows[$];
    row_t exp_q[$];

    function automatic robIdx_t ri(input logic f, input int i);
        robIdx_t r;
        r.flag = f;
        r.idx  = ROB_IDX_W'(i);
        return r;
    endfunction

    function automatic branchwbInfo_t wb(input logic f, input int i, input logic t, input xdef_t tgt, input xdef_t npc, input logic mis);
        branchwbInfo_t w;
        w.rob_idx      = ri(f, i);
        w.has_mispred  = mis;
        w.branch_taken = t;
        w.target_pc    = tgt;
        w.branch_npc   = npc;
        return w;
    endfunction

    function automatic squashInfo_t sq(input logic t, input xdef_t pc);
        squashInfo_t s;
        s.dueToBranch  = 1'b1;
        s.branch_taken = t;
        s.arch_pc      = pc;
        return s;
    endfunction

    task automatic add(input logic [1:0] vld, input branchwbInfo_t w0, input branchwbInfo_t w1,
                       input logic cvld, input robIdx_t hd, input logic fl, input logic rd,
                       input logic e_sq, input squashInfo_t e_info, input logic e_cb,
                       input logic e_pv, input robIdx_t e_pidx, input logic e_tmo);
        row_t r;
        r.vld = vld; r.w0 = w0; r.w1 = w1; r.cvld = cvld; r.head = hd; r.flush = fl; r.rdone = rd;
        r.e_sq = e_sq; r.e_info = e_info; r.e_cb = e_cb; r.e_pv = e_pv; r.e_pidx = e_pidx; r.e_tmo = e_tmo;
        rows.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        wb_vld = '0; wb_info[0] = '0; wb_info[1] = '0;
        commit_vld = 1'b0; head = '0; ext_flush = 1'b0; restore_done = 1'b0;
    endtask

    initial begin
        branchwbInfo_t n;
        robIdx_t z;
        row_t r;
        row_t e;
        n = '0;
        z = '0;
        drive_idle();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_squash_vld", 64'(squash_vld), 64'd0);
        chk("reset_squash_info", 64'(squash_info), 64'd0);
        chk("reset_commit_block", 64'(commit_block), 64'd0);
        chk("reset_pend_vld", 64'(pend_vld), 64'd0);
        chk("reset_pend_idx", 64'(pend_rob_idx), 64'd0);
        chk("reset_timeout", 64'(restore_timeout), 64'd0);
        rst = 1'b1;

        // Single mispredict, wrong-head commit ignored, squash-cycle writeback ignored
        add(2'b01, wb(0,5,1,32'h8000_1000,32'h8000_0004,1), n, 0,z,0,0, 0,'0,0,1,ri(0,5),0);
        add(2'b00, n, n, 1,ri(0,4),0,0, 0,'0,0,1,ri(0,5),0);
        add(2'b00, n, n, 1,ri(0,5),0,0, 1,sq(1,32'h8000_1000),1,0,ri(0,5),0);
        add(2'b01, wb(0,1,1,32'h1,32'h2,1), n, 0,z,0,0, 0,'0,1,0,ri(0,5),0);
        add(2'b00, n, n, 0,z,0,0, 0,'0,1,0,ri(0,5),0);
        add(2'b00, n, n, 0,z,0,1, 0,'0,0,0,ri(0,5),0);
        // Non-mispredict ignored; two ports same cycle
        add(2'b01, wb(0,2,1,32'h5,32'h6,0), n, 0,z,0,0, 0,'0,0,0,ri(0,5),0);
        add(2'b11, wb(0,9,1,32'hA000_0000,32'hA000_0004,1), wb(0,3,0,32'h9000_0000,32'h4000_0010,1), 0,z,0,0, 0,'0,0,1,ri(0,3),0);
        add(2'b00, n, n, 1,ri(0,3),0,0, 1,sq(0,32'h4000_0010),1,0,ri(0,3),0);
        add(2'b00, n, n, 0,z,0,0, 0,'0,1,0,ri(0,3),0);
        add(2'b00, n, n, 0,z,0,1, 0,'0,0,0,ri(0,3),0);
        // Wrap ordering
        add(2'b01, wb(0,60,1,32'hB000_0000,32'hB000_0004,1), n, 0,z,0,0, 0,'0,0,1,ri(0,60),0);
        add(2'b10, n, wb(1,2,1,32'hB100_0000,32'hB100_0004,1), 0,z,0,0, 0,'0,0,1,ri(0,60),0);
        add(2'b00, n, n, 0,z,1,0, 0,'0,0,0,z,0);
        add(2'b01, wb(1,2,1,32'hB100_0000,32'hB100_0004,1), n, 0,z,0,0, 0,'0,0,1,ri(1,2),0);
        add(2'b10, n, wb(0,60,0,32'hC000_0000,32'hC000_0004,1), 0,z,0,0, 0,'0,0,1,ri(0,60),0);
        // Flush in PENDING, flush with capture, flush with commit-match
        add(2'b00, n, n, 0,z,1,0, 0,'0,0,0,z,0);
        add(2'b01, wb(0,1,1,32'h7,32'h8,1), n, 0,z,1,0, 0,'0,0,0,z,0);
        add(2'b01, wb(0,7,1,32'hC100_0000,32'hC100_0004,1), n, 0,z,0,0, 0,'0,0,1,ri(0,7),0);
        add(2'b00, n, n, 1,ri(0,7),1,0, 0,'0,0,0,z,0);
        add(2'b00, n, n, 0,z,0,0, 0,'0,0,0,z,0);
        // Capture and commit-match together: held branch squashes, candidate dropped
        add(2'b01, wb(0,20,1,32'hD000_0000,32'hD000_0004,1), n, 0,z,0,0, 0,'0,0,1,ri(0,20),0);
        add(2'b10, n, wb(0,10,1,32'hD100_0000,32'hD100_0004,1), 1,ri(0,20),0,0, 1,sq(1,32'hD000_0000),1,0,ri(0,20),0);
        add(2'b00, n, n, 0,z,0,0, 0,'0,1,0,ri(0,20),0);
        add(2'b00, n, n, 0,z,0,1, 0,'0,0,0,ri(0,20),0);
        // Age tie: lowest port wins
        add(2'b11, wb(0,12,0,32'hE000_0000,32'h1111_0000,1), wb(0,12,1,32'h2222_0000,32'h3333_0000,1), 0,z,0,0, 0,'0,0,1,ri(0,12),0);
        add(2'b00, n, n, 1,ri(0,12),0,0, 1,sq(0,32'h1111_0000),1,0,ri(0,12),0);
        add(2'b00, n, n, 0,z,0,0, 0,'0,1,0,ri(0,12),0);
        add(2'b00, n, n, 0,z,0,1, 0,'0,0,0,ri(0,12),0);
        // Restore timeout, sticky through return to IDLE
        add(2'b01, wb(0,30,1,32'hF000_0000,32'hF000_0004,1), n, 0,z,0,0, 0,'0,0,1,ri(0,30),0);
        add(2'b00, n, n, 1,ri(0,30),0,0, 1,sq(1,32'hF000_0000),1,0,ri(0,30),0);
        add(2'b00, n, n, 0,z,0,0, 0,'0,1,0,ri(0,30),0);
        for (int k = 1; k <= TMO + 3; k++) begin
            add(2'b00, n, n, 0,z,0,0, 0,'0,1,0,ri(0,30),(k >= TMO));
        end
        add(2'b00, n, n, 0,z,0,1, 0,'0,0,0,ri(0,30),1);
        add(2'b01, wb(0,40,0,32'h1,32'h2,1), n, 0,z,0,0, 0,'0,0,1,ri(0,40),1);
        add(2'b00, n, n, 0,z,1,0, 0,'0,0,0,z,1);

        // Apply rows; expectations enter the scoreboard as stimulus is driven
        #1;
        for (int i = 0; i < rows.size(); i++) begin
            r = rows[i];
            wb_vld = r.vld; wb_info[0] = r.w0; wb_info[1] = r.w1;
            commit_vld = r.cvld; head = r.head; ext_flush = r.flush; restore_done = r.rdone;
            exp_q.push_back(r);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("row%0d_squash_vld", i), 64'(squash_vld), 64'(e.e_sq));
            chk($sformatf("row%0d_squash_info", i), 64'(squash_info), 64'(e.e_info));
            chk($sformatf("row%0d_commit_block", i), 64'(commit_block), 64'(e.e_cb));
            chk($sformatf("row%0d_pend_vld", i), 64'(pend_vld), 64'(e.e_pv));
            chk($sformatf("row%0d_pend_idx", i), 64'(pend_rob_idx), 64'(e.e_pidx));
            chk($sformatf("row%0d_timeout", i), 64'(restore_timeout), 64'(e.e_tmo));
        end
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        // Reset asserted mid-SQUASH drops outputs without a clock edge
        drive_idle();
        wb_vld = 2'b01; wb_info[0] = wb(0,50,1,32'h1234_5678,32'h0,1);
        @(posedge clk); #1;
        drive_idle();
        commit_vld = 1'b1; head = ri(0,50);
        @(posedge clk); #1;
        drive_idle();
        chk("pre_reset_squash_vld", 64'(squash_vld), 64'd1);
        chk("pre_reset_squash_info", 64'(squash_info), 64'(sq(1,32'h1234_5678)));
        #2 rst = 1'b0;
        #1;
        chk("async_reset_squash_vld", 64'(squash_vld), 64'd0);
        chk("async_reset_commit_block", 64'(commit_block), 64'd0);
        chk("async_reset_squash_info", 64'(squash_info), 64'd0);
        chk("async_reset_timeout", 64'(restore_timeout), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_pend_vld", 64'(pend_vld), 64'd0);
        chk("post_reset_commit_block", 64'(commit_block), 64'd0);
        wb_vld = 2'b10; wb_info[1] = wb(1,51,0,32'h0,32'h4,1);
        @(posedge clk); #1;
        drive_idle();
        chk("post_reset_capture_vld", 64'(pend_vld), 64'd1);
        chk("post_reset_capture_idx", 64'(pend_rob_idx), 64'(ri(1,51)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
